// File: rtl/seg_pkg.sv
// Shared constants, FSM state type and hex glyph table for the eight-digit
// multiplexed seven-segment scanner.
package seg_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-low glyphs, bit 0 = CA ... bit 6 = CG; index 15 (F) is listed first.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display bus between the digit source (master) and the scanner (slave), plus
// the scanner's debug view of its FSM state and digit index.
interface seg_scan_driver_if;
    import seg_pkg::*;

    // No handshake: the scanner samples sevenseg/digital_enable/dp_bitmap only
    // on the cycle frame_start is high; the source may change them at any time.
    logic [31:0] sevenseg;
    logic [7:0]  digital_enable;
    logic [7:0]  dp_bitmap;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;
    state_t      dbg_state;
    logic [2:0]  dbg_idx;

    modport master (
        output sevenseg, digital_enable, dp_bitmap,
        input  an, seg, dp, frame_start, dbg_state, dbg_idx
    );

    modport slave (
        input  sevenseg, digital_enable, dp_bitmap,
        output an, seg, dp, frame_start, dbg_state, dbg_idx
    );

endinterface

// File: rtl/hex_to_7seg.sv
// Combinational 4-bit code to active-low seven-segment glyph lookup.
module hex_to_7seg
    import seg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] glyph
);

    assign glyph = GLYPH_TABLE[code];

endmodule

// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed seven-segment scanner with per-slot blanking and
// frame-wide input snapshot. Optional macro: SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    seg_scan_driver_if.slave bus
);

    generate
        if (DIGIT_CYCLES < 2 || BLANK_CYCLES >= DIGIT_CYCLES) begin : g_bad_params
            $error("seg_scan_driver: need DIGIT_CYCLES >= 2 and BLANK_CYCLES < DIGIT_CYCLES");
        end
    endgenerate

    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_DRIVE = CW'(BLANK_CYCLES);

    state_t          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            armed_q, armed_d;
    logic [31:0]     snap_sev_q, snap_sev_d;
    logic [7:0]      snap_en_q, snap_en_d;
    logic [7:0]      snap_dp_q, snap_dp_d;
    logic [7:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            frame_start_q, frame_start_d;

    logic [3:0]      digit_code;
    logic [6:0]      glyph;
    logic            digit_dark;
    logic            lit;

    // armed_q is clear only between reset release and the first clock edge,
    // which is treated as the entry into BLANK of digit 0.
    always_comb begin
        armed_d       = 1'b1;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        frame_start_d = 1'b0;
        if (!armed_q) begin
            cnt_d         = '0;
            idx_d         = 3'd0;
            frame_start_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d         = '0;
            idx_d         = idx_q + 3'd1;
            frame_start_d = (idx_q == 3'd7);
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        state_d = (cnt_d < CNT_DRIVE) ? ST_BLANK : ST_DRIVE;

        snap_sev_d = snap_sev_q;
        snap_en_d  = snap_en_q;
        snap_dp_d  = snap_dp_q;
        if (frame_start_d) begin
            snap_sev_d = bus.sevenseg;
            snap_en_d  = bus.digital_enable;
            snap_dp_d  = bus.dp_bitmap;
        end
    end

    assign digit_code = snap_sev_d[{idx_d, 2'b00} +: 4];

    hex_to_7seg u_hex (
        .code  (digit_code),
        .glyph (glyph)
    );

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_dark;
    logic                  higher_zero;

    // A digit goes dark when it and every enabled digit above it reads zero.
    always_comb begin
        lz_dark     = '0;
        higher_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lz_dark[i]  = higher_zero && (snap_sev_d[4*i +: 4] == 4'h0);
            higher_zero = higher_zero && (!snap_en_d[i] || (snap_sev_d[4*i +: 4] == 4'h0));
        end
    end

    assign digit_dark = lz_dark[idx_d];
`else
    assign digit_dark = 1'b0;
`endif

    // Outputs are decoded from next-state values so the registered pins line
    // up with the state and idx present after the same edge.
    always_comb begin
        lit  = (state_d == ST_DRIVE) && snap_en_d[idx_d] && !digit_dark;
        an_d = AN_OFF;
        seg_d = SEG_OFF;
        dp_d = 1'b1;
        if (lit) begin
            an_d  = ~(8'b1 << idx_d);
            seg_d = glyph;
            dp_d  = ~snap_dp_d[idx_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_BLANK;
            idx_q         <= 3'd0;
            cnt_q         <= '0;
            armed_q       <= 1'b0;
            snap_sev_q    <= '0;
            snap_en_q     <= '0;
            snap_dp_q     <= '0;
            an_q          <= AN_OFF;
            seg_q         <= SEG_OFF;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            armed_q       <= armed_d;
            snap_sev_q    <= snap_sev_d;
            snap_en_q     <= snap_en_d;
            snap_dp_q     <= snap_dp_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.an          = an_q;
    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.frame_start = frame_start_q;
    assign bus.dbg_state   = state_q;
    assign bus.dbg_idx     = idx_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed, table-driven bench for seg_scan_driver with DIGIT_CYCLES=16 and
// BLANK_CYCLES=2; honours SEG_LEADING_ZERO_BLANK_EN when defined.
module tb_seg_scan_driver;
    import seg_pkg::*;

    localparam int DC = 16;
    localparam int BC = 2;
    localparam int NV = 7;

    typedef struct {
        logic [31:0]      sev;
        logic [7:0]       en;
        logic [7:0]       dpb;
        int               mid_digit;
        logic [31:0]      mid_sev;
        logic [7:0][7:0]  an;
        logic [7:0][6:0]  seg;
        logic [7:0]       dpv;
    } vec_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    vec_t tbl[NV];

    seg_scan_driver_if bus();

    seg_scan_driver #(
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int v);
        bus.sevenseg       = tbl[v].sev;
        bus.digital_enable = tbl[v].en;
        bus.dp_bitmap      = tbl[v].dpb;
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.frame_start && n < 300);
    endtask

    // Starts on the negedge where frame_start was seen; checks every cycle of the frame.
    task automatic check_frame(input int v);
        logic [16:0] act;
        logic [16:0] exp;
        for (int d = 0; d < 8; d++) begin
            for (int c = 0; c < DC; c++) begin
                if (d > 0 || c > 0) @(negedge clk);
                if (c == 0 && d == tbl[v].mid_digit) bus.sevenseg = tbl[v].mid_sev;
                act = {bus.frame_start, bus.an, bus.seg, bus.dp};
                if (c < BC) exp = {(d == 0 && c == 0), AN_OFF, SEG_OFF, 1'b1};
                else        exp = {1'b0, tbl[v].an[d], tbl[v].seg[d], tbl[v].dpv[d]};
                check($sformatf("v%0d_d%0d_c%0d {fs,an,seg,dp}", v, d, c), 32'(act), 32'(exp));
            end
        end
    endtask

    initial begin
        int n;
        n_tests = 0;
        n_fail  = 0;

        tbl[0] = '{32'h76543210, 8'hFF, 8'h04, 8, 32'h0,
                   {8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE},
                   {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}, 8'hFB};
        tbl[1] = '{32'h76543210, 8'h07, 8'h04, 8, 32'h0,
                   {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFB, 8'hFD, 8'hFE},
                   {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h24, 7'h79, 7'h40}, 8'hFB};
        tbl[2] = '{32'hFEDCBA98, 8'hFF, 8'hFF, 8, 32'h0,
                   {8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE},
                   {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00}, 8'h00};
        tbl[3] = '{32'h89ABCDEF, 8'hAA, 8'h55, 8, 32'h0,
                   {8'h7F, 8'hFF, 8'hDF, 8'hFF, 8'hF7, 8'hFF, 8'hFD, 8'hFF},
                   {7'h00, 7'h7F, 7'h08, 7'h7F, 7'h46, 7'h7F, 7'h06, 7'h7F}, 8'hFF};
`ifdef SEG_LEADING_ZERO_BLANK_EN
        tbl[4] = '{32'h00000105, 8'hFF, 8'h08, 8, 32'h0,
                   {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFB, 8'hFD, 8'hFE},
                   {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h12}, 8'hFF};
        tbl[5] = '{32'h00000000, 8'hFF, 8'h00, 4, 32'h11111111,
                   {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE},
                   {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 8'hFF};
`else
        tbl[4] = '{32'h00000105, 8'hFF, 8'h08, 8, 32'h0,
                   {8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE},
                   {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h40, 7'h12}, 8'hF7};
        tbl[5] = '{32'h00000000, 8'hFF, 8'h00, 4, 32'h11111111,
                   {8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE},
                   {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 8'hFF};
`endif
        tbl[6] = '{32'h11111111, 8'hFF, 8'h80, 8, 32'h0,
                   {8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE},
                   {7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79}, 8'h7F};

        // Reset state
        rst = 1'b1;
        drive(0);
        repeat (3) @(negedge clk);
        check("rst_an", 32'(bus.an), 32'h0000_00FF);
        check("rst_seg", 32'(bus.seg), 32'h0000_007F);
        check("rst_dp", 32'(bus.dp), 32'h1);
        check("rst_frame_start", 32'(bus.frame_start), 32'h0);
        check("rst_state", 32'(bus.dbg_state), 32'(ST_BLANK));
        check("rst_idx", 32'(bus.dbg_idx), 32'h0);
        rst = 1'b0;

        // Table-driven frames, back to back
        for (int v = 0; v < NV; v++) begin
            if (v > 0) drive(v);
            wait_frame(n);
            check($sformatf("v%0d_frame_gap", v), 32'(n), 32'd1);
            check_frame(v);
        end

        // Reset asserted mid-DRIVE of digit 5, then a fresh frame from digit 0
        wait_frame(n);
        check("pre_rst_frame_gap", 32'(n), 32'd1);
        repeat (5 * DC + 5) @(negedge clk);
        check("pre_rst_an", 32'(bus.an), 32'h0000_00DF);
        check("pre_rst_seg", 32'(bus.seg), 32'h0000_0079);
        #2;
        rst = 1'b1;
        drive(2);
        #1;
        check("async_rst_an", 32'(bus.an), 32'h0000_00FF);
        check("async_rst_seg", 32'(bus.seg), 32'h0000_007F);
        check("async_rst_dp", 32'(bus.dp), 32'h1);
        check("async_rst_frame_start", 32'(bus.frame_start), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_frame(n);
        check("post_rst_frame_latency", 32'(n), 32'd1);
        check_frame(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter DIGIT_CYCLES, default 100000, clocks per digit time slot (1 kHz per digit at 100 MHz).
REQ-002 SHALL have parameter BLANK_CYCLES, default 1000, dead-time clocks at the start of each slot.
REQ-003 SHALL have port clk  input  1  system clock, 100 MHz.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port sevenseg  input  32  eight 4-bit digit codes; digit i is bits [4i+3:4i].
REQ-006 SHALL have port digital_enable  input  8  per-digit enable, 1 = digit lit.
REQ-007 SHALL have port dp_bitmap  input  8  per-digit decimal point, 1 = point on.
REQ-008 SHALL have port an  output  8  anodes, active-low, an[i] = digit i.
REQ-009 SHALL have port seg  output  7  cathodes, active-low, seg[0]=CA ... seg[6]=CG.
REQ-010 SHALL have port dp  output  1  decimal-point cathode, active-low.
REQ-011 SHALL have port frame_start  output  1  one-clock pulse when a new input snapshot is taken.
REQ-012 SHALL use one clock (clk) and an asynchronous, active-high reset (rst).

Function
REQ-013 SHALL be a two-state FSM: BLANK -> DRIVE -> BLANK, with a 3-bit digit index idx and a slot counter.
- BLANK: lasts BLANK_CYCLES clocks; an=8'hFF, seg=7'h7F, dp=1.
- DRIVE: lasts DIGIT_CYCLES-BLANK_CYCLES clocks; an[idx]=0 only if the snapshot enable[idx]=1, otherwise an=8'hFF.
REQ-014 SHALL advance idx on the DRIVE->BLANK edge, with wrap 7->0; each slot is exactly DIGIT_CYCLES clocks and a frame is 8*DIGIT_CYCLES clocks.
REQ-015 SHALL capture sevenseg, digital_enable and dp_bitmap into snapshot registers on entry to BLANK with idx=0, including the first BLANK after reset; frame_start SHALL be 1 on that same cycle.
REQ-016 SHALL make input changes mid-frame invisible until the next snapshot (no tearing).
REQ-017 SHALL register an, seg and dp, each reflecting the state and idx present after the same clock edge.
REQ-018 SHALL decode codes 0-F to hex glyphs.
- Examples: 0->7'h40, 1->7'h79, 8->7'h00, A->7'h08, F->7'h0E.
- Code A-F SHALL display, not blank; the upstream stopwatch can briefly present code A.
REQ-019 SHALL set dp=0 during DRIVE only when snapshot dp_bitmap[idx]=1 and enable[idx]=1.
REQ-020 SHALL not synthesize a DIGIT_CYCLES<2 or BLANK_CYCLES>=DIGIT_CYCLES setting; it SHALL fail elaboration.

Reset
REQ-021 SHALL, while rst=1, force immediately and asynchronously: an=8'hFF, seg=7'h7F, dp=1, frame_start=0, state=BLANK, idx=0, counter=0, snapshot=0.
REQ-022 SHALL, on a reset asserted mid-slot, abandon the slot; after release, scanning restarts at BLANK of digit 0 with a fresh snapshot.

Configuration
REQ-023 SHALL support macro SEG_LEADING_ZERO_BLANK_EN.
- Defined: during DRIVE, digit i>=1 is dark (an=8'hFF, dp=1) when its code and the codes of all enabled higher digits are 0; digit 0 is never blanked.
- Undefined: all enabled digits display, zeros included; no extra logic is generated.

Structure
REQ-024 SHALL place NUM_DIGITS=8, the 16-entry glyph table, SEG_OFF=7'h7F and AN_OFF=8'hFF in shared package seg_pkg.
REQ-025 SHALL instantiate one combinational sub-module, hex_to_7seg (4-bit code in, 7-bit active-low glyph out).

Verification (DIGIT_CYCLES=16, BLANK_CYCLES=2)
REQ-026 SHALL cover input sevenseg=32'h76543210, enable=8'hFF, dp_bitmap=8'h04.
- Required: an steps FE,FD,...,7F, 14 clocks each, separated by 2 clocks of FF.
- Required: seg 40,79,24,30,19,12,02,78; dp=0 only while an=FB; frame_start period 128 clocks.
REQ-027 SHALL cover input enable=8'h07 -> digits 3-7 hold an=8'hFF for their full slots, and frame period stays 128.
REQ-028 SHALL cover a change of sevenseg from 0 to 32'h11111111 at digit 4 -> digits 4-7 still show 7'h40; the new value shows after the next frame_start.
REQ-029 SHALL cover rst pulsed during DRIVE of digit 5 -> an=FF, seg=7F the same cycle without a clock edge; after release, 2 BLANK clocks, then digit 0 is driven and frame_start=1 on the first cycle.
REQ-030 SHALL cover input sevenseg=32'h00000105, enable=8'hFF.
- With SEG_LEADING_ZERO_BLANK_EN: digits 3-7 dark, digits 2,1,0 show 79,40,12.
- Without: all eight digits lit.
